// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, reset vector default and PC step.
package mips_fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DROP    = 3'd3,
        ST_FAULT   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] INSTRUCTION_STEP     = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_output_buffer.sv
// One-entry holding register between instruction memory and decode.
// Flush wins over load; a load in the same cycle as a consume keeps the entry valid.
module fetch_output_buffer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        flush,
    input  logic        consume,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc
);

    logic        valid_r;
    logic [31:0] data_r;
    logic [31:0] pc_r;

    // Entry register: flush, load new word, or clear on consume
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            pc_r    <= 32'h0000_0000;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            pc_r    <= load_pc;
        end else if (consume && valid_r) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign instruction_valid = valid_r;
    assign instruction       = data_r;
    assign instruction_pc    = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM with next-PC mux, single outstanding memory request,
// redirect handling with response drop, and sticky misaligned-fetch fault.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instruction_address,
    output logic [31:0] next_instruction_address,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        fetch_fault
);

    fetch_state_e state_r;
    fetch_state_e state_s;
    logic [31:0]  fetch_pc_r;
    logic         fetch_fault_r;
    logic [31:0]  next_pc_s;
    logic         req_valid_s;
    logic         latch_pc_s;
    logic         buf_load_s;
    logic         buf_flush_s;
    logic         fault_set_s;
    logic         buf_free_s;

    assign buf_free_s = ~instruction_valid | instruction_ready;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, next-PC mux and buffer control
    always_comb begin
        state_s     = state_r;
        next_pc_s   = instruction_address;
        req_valid_s = 1'b0;
        latch_pc_s  = 1'b0;
        buf_load_s  = 1'b0;
        buf_flush_s = 1'b0;
        fault_set_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                next_pc_s = RESET_VECTOR;
                state_s   = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (is_misaligned(instruction_address)) begin
                    fault_set_s = 1'b1;
                    buf_flush_s = 1'b1;
                    state_s     = ST_FAULT;
                end else begin
                    req_valid_s = buf_free_s;
                    if (buf_free_s && mem_req_ready) begin
                        latch_pc_s = 1'b1;
                        next_pc_s  = instruction_address + INSTRUCTION_STEP;
                        state_s    = ST_WAIT;
                    end else begin
                        state_s = ST_REQUEST;
                    end
                    // A request accepted alongside a redirect fetches a dead path; drop its response
                    if (redirect_valid) begin
                        next_pc_s   = redirect_address;
                        buf_flush_s = 1'b1;
                        state_s     = latch_pc_s ? ST_DROP : ST_REQUEST;
                    end else begin
                        buf_flush_s = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    next_pc_s   = redirect_address;
                    buf_flush_s = 1'b1;
                    state_s     = mem_resp_valid ? ST_REQUEST : ST_DROP;
                end else if (mem_resp_valid) begin
                    buf_load_s = 1'b1;
                    state_s    = ST_REQUEST;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    next_pc_s   = redirect_address;
                    buf_flush_s = 1'b1;
                end else begin
                    next_pc_s = instruction_address;
                end
                if (mem_resp_valid) begin
                    state_s = ST_REQUEST;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_FAULT: begin
                buf_flush_s = 1'b1;
                state_s     = ST_FAULT;
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // Fetch address of the outstanding request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= 32'h0000_0000;
        end else if (latch_pc_s) begin
            fetch_pc_r <= instruction_address;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fetch_fault_r <= 1'b1;
        end else begin
            fetch_fault_r <= fetch_fault_r;
        end
    end

    fetch_output_buffer u_buffer (
        .clock             (clock),
        .reset_n           (reset_n),
        .load              (buf_load_s),
        .flush             (buf_flush_s),
        .consume           (instruction_ready),
        .load_data         (mem_resp_data),
        .load_pc           (fetch_pc_r),
        .instruction_valid (instruction_valid),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc)
    );

    assign next_instruction_address = next_pc_s;
    assign mem_req_valid            = req_valid_s;
    assign mem_address              = instruction_address;
    assign fetch_fault              = fetch_fault_r;

endmodule
